// File: rtl/mesh_link_pkg.sv
// Shared constants and helpers for the PE mesh inter-tile links.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Default link widths match the mesh directional buses: east/west carry
// LINK_EW_WIDTH bits, north/south carry LINK_NS_WIDTH bits.
package mesh_link_pkg;

  localparam int LINK_EW_WIDTH = 131;
  localparam int LINK_NS_WIDTH = 167;
  localparam int LINK_DEPTH    = 4;

  // Ceiling log2, usable in parameter defaults. The bounded loop keeps it
  // elaboration-friendly for every tool.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/link_fifo_mem.sv
// Storage array for the link buffer: DEPTH x DATA_WIDTH registers.
// Latency: write lands on the clock edge; read is asynchronous (same cycle).
// Backpressure: none here; the owner decides when wr_en may be asserted.
//
// Ports:
//   clk      - write clock
//   wr_en    - write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr  - write index
//   wr_data  - word to store
//   rd_addr  - read index
//   rd_data  - word currently held at rd_addr
//
// Contents are deliberately not reset: the owner's level counter decides
// which entries are meaningful, so the array never needs clearing.
module link_fifo_mem #(
  parameter int DATA_WIDTH = 131,
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_link_buffer.sv
// Elastic buffer on one inter-tile PE mesh link; also strobes the downstream PE's ap_start once per delivered word.
// Latency: 1 cycle from push to out_valid (first-word fall-through, no combinational in->out path).
// Backpressure: in_ready drops when DEPTH words are held; a pop in the same cycle does not reopen it.
//
// Ports:
//   clk          - single clock
//   reset        - asynchronous, active-low reset
//   in_data      - word from the upstream PE's directional output bus
//   in_valid     - upstream word valid
//   in_ready     - buffer accepts a word this cycle
//   out_data     - head word, drives the downstream PE's input bus
//   out_valid    - head word valid
//   out_ready    - downstream can consume this cycle
//   ap_start_out - one-cycle strobe to the downstream PE, high on every pop
//   flush        - synchronous clear of all contents and statistics
//   level        - current occupancy, 0..DEPTH
//   max_level    - high-water mark since reset or the last flush
module pe_link_buffer
  import mesh_link_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_EW_WIDTH,
  parameter int DEPTH      = LINK_DEPTH,
  parameter int ADDR_BITS  = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ap_start_out,
  input  logic                  flush,
  output logic [ADDR_BITS:0]    level,
  output logic [ADDR_BITS:0]    max_level
);

  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    level_q;
  logic [ADDR_BITS:0]    level_nxt;
  logic [ADDR_BITS:0]    max_q;
  logic                  accept_en;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;

  // accept_en holds in_ready low while reset is asserted and opens it on the
  // first clock edge after release, so the upstream PE never sees a ready
  // buffer during reset.
  assign in_ready  = accept_en & (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);

  // A flush discards any same-cycle transfer, so both handshakes are masked
  // here; this also keeps ap_start_out low during the flush cycle.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign ap_start_out = pop;

  // Driving zero while empty makes out_data read 0 during reset instead of
  // exposing whatever the unreset array holds.
  assign out_data = out_valid ? head_data : '0;

  assign level     = level_q;
  assign max_level = max_q;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_en <= 1'b0;
    end else begin
      accept_en <= 1'b1;
    end
  end

  // Pointers are ADDR_BITS wide and DEPTH is a power of two, so natural
  // overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      max_q   <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      max_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_nxt;
      if (level_nxt > max_q) begin
        max_q <= level_nxt;
      end
    end
  end

  link_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

endmodule

// File: tb/tb_pe_link_buffer.sv
// Self-checking bench for pe_link_buffer: queue-based reference model compared every cycle, plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: exercised via out_ready patterns from the directed sequence.
module tb_pe_link_buffer;

  localparam int DW    = 131;
  localparam int DEPTH = 4;
  localparam int AB    = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ap_start_out;
  logic          flush;
  logic [AB:0]   level;
  logic [AB:0]   max_level;

  int checks   = 0;
  int failures = 0;
  int ap_cnt   = 0;

  // Reference model: a plain queue of outstanding words plus a high-water mark.
  logic [DW-1:0] mq [$];
  int            m_max   = 0;
  bit            m_ready = 0;

  pe_link_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (AB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ap_start_out (ap_start_out),
    .flush        (flush),
    .level        (level),
    .max_level    (max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return m_ready && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_pop();
    return (mq.size() > 0) && out_ready && !flush;
  endfunction

  function automatic bit m_push();
    return in_valid && m_in_ready() && !flush;
  endfunction

  // Model state update on the same edge the DUT uses.
  always @(posedge clk) begin
    if (reset) begin
      if (flush) begin
        mq.delete();
        m_max = 0;
      end else begin
        bit do_pop;
        bit do_push;
        do_pop  = m_pop();
        do_push = m_push();
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(in_data);
        if (mq.size() > m_max) m_max = mq.size();
      end
      m_ready = 1;
    end
  end

  always @(negedge reset) begin
    mq.delete();
    m_max   = 0;
    m_ready = 0;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("m_out_valid", {130'd0, out_valid}, {130'd0, mq.size() > 0});
    chk("m_in_ready", {130'd0, in_ready}, {130'd0, m_in_ready()});
    chk("m_level", DW'(level), DW'(mq.size()));
    chk("m_max_level", DW'(max_level), DW'(m_max));
    chk("m_ap_start", {130'd0, ap_start_out}, {130'd0, m_pop()});
    if (mq.size() > 0) chk("m_out_data", out_data, mq[0]);
    if (!reset) chk("m_out_data_rst", out_data, '0);
    if (ap_start_out) ap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", {130'd0, out_valid}, '0);
    chk("rst_in_ready", {130'd0, in_ready}, '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_out_data", out_data, '0);

    // Release, then single word.
    reset = 1'b1;
    step();
    chk("ready_after_release", {130'd0, in_ready}, DW'(1));
    in_valid = 1'b1; in_data = DW'(1);
    step();
    in_valid = 1'b0;
    chk("single_valid", {130'd0, out_valid}, DW'(1));
    chk("single_data", out_data, DW'(1));
    chk("single_level", DW'(level), DW'(1));
    base = ap_cnt;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_drained", DW'(level), '0);
    chk("single_ap_pulses", DW'(ap_cnt - base), DW'(1));

    // Fill and backpressure; fifth word refused.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(32'hA + i);
      step();
    end
    in_valid = 1'b0;
    chk("fill_level", DW'(level), DW'(4));
    chk("fill_in_ready", {130'd0, in_ready}, '0);
    chk("fill_max", DW'(max_level), DW'(4));
    base = ap_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", out_data, DW'(32'hA + i));
      step();
    end
    out_ready = 1'b0;
    chk("fill_ap_pulses", DW'(ap_cnt - base), DW'(4));
    chk("fill_empty", {130'd0, out_valid}, '0);

    // Streaming 20 words through with wrap.
    base = ap_cnt;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'(i);
      step();
      if (i > 0) chk("stream_head", out_data, DW'(i));
      if (level > 1) chk("stream_level_le1", DW'(level), DW'(1));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_ap_pulses", DW'(ap_cnt - base), DW'(20));
    chk("stream_empty", DW'(level), '0);

    // Full plus simultaneous pop: no push while full.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(32'h30 + i);
      step();
    end
    in_data = DW'(32'h34); out_ready = 1'b1;
    step();
    chk("full_pop_only", DW'(level), DW'(3));
    chk("full_pop_head", out_data, DW'(32'h31));
    in_data = DW'(32'h35);
    step();
    chk("push_and_pop", DW'(level), DW'(3));
    chk("push_and_pop_head", out_data, DW'(32'h32));

    // Flush with traffic on both sides.
    in_data = DW'(32'h36); flush = 1'b1;
    #1;
    chk("flush_ap_zero", {130'd0, ap_start_out}, '0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_level", DW'(level), '0);
    chk("flush_max", DW'(max_level), '0);
    chk("flush_valid", {130'd0, out_valid}, '0);

    // Async reset mid-stream with two words queued.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(32'h50 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", DW'(level), DW'(2));
    #1;
    reset = 1'b0;
    #1;
    chk("async_valid", {130'd0, out_valid}, '0);
    chk("async_level", DW'(level), '0);
    chk("async_in_ready", {130'd0, in_ready}, '0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    base = ap_cnt;
    repeat (3) step();
    chk("no_stale_valid", {130'd0, out_valid}, '0);
    chk("no_stale_ap", DW'(ap_cnt - base), '0);
    in_valid = 1'b1; in_data = DW'(32'h60);
    step();
    in_valid = 1'b0;
    chk("post_rst_data", out_data, DW'(32'h60));
    step();
    chk("post_rst_drained", DW'(level), '0);
    chk("post_rst_max", DW'(max_level), DW'(1));
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
